// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: STAGES-deep shift of {valid, payload}
// with hazard stall, flush-to-bubble and saturating stall/bubble counters.
module pipe_stage_reg #(
  parameter int unsigned   DW     = 64,
  parameter int unsigned   STAGES = 1,
  parameter logic [DW-1:0] BUBBLE = '0,
  parameter int unsigned   CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             stall,
  input  logic             flush,
  input  logic             clr_cnt,
  input  logic             valid_in,
  input  logic [DW-1:0]    data_in,
  output logic             valid_out,
  output logic [DW-1:0]    data_out,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic hit;
  logic advance;
  logic stall_inc;
  logic bubble_inc;

  logic [STAGES-1:0] valid_q;
  logic [DW-1:0]     data_q [STAGES];
  logic [STAGES-1:0] shift_valid;
  logic [DW-1:0]     shift_data [STAGES];

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    hit        = ihit | dhit;
    advance    = hit & ~stall;
    stall_inc  = hit & stall & ~flush;
    bubble_inc = flush | (advance & ~valid_in);
  end

  // Shifted view of the pipe: stage k takes stage k-1, stage 0 takes the input.
  assign shift_valid[0] = valid_in;
  assign shift_data[0]  = data_in;
  for (genvar k = 1; k < STAGES; k++) begin : g_shift
    assign shift_valid[k] = valid_q[k-1];
    assign shift_data[k]  = data_q[k-1];
  end

  always_ff @(posedge CLK) begin
    if (!nRST || flush) begin
      valid_q <= '0;
      data_q  <= '{default: BUBBLE};
    end else if (advance) begin
      valid_q <= shift_valid;
      data_q  <= shift_data;
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (bubble_inc && (bubble_cnt_q != '1)) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign valid_out  = valid_q[STAGES-1];
  assign data_out   = data_q[STAGES-1];
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: 3-stage instance checked by an output scoreboard plus
// directed checks; a 1-stage, 2-bit-counter instance covers counter saturation.
module tb_pipe_stage_reg;

  localparam logic [7:0] Bub = 8'hA5;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       ihit = 1'b0, dhit = 1'b0, stall = 1'b0, flush = 1'b0, clr = 1'b0;
  logic       vin = 1'b0;
  logic [7:0] din = 8'h00;
  logic       valid_out;
  logic [7:0] data_out;
  logic [15:0] stall_cnt, bubble_cnt;

  logic       ihit2 = 1'b0, stall2 = 1'b0, clr2 = 1'b0, vin2 = 1'b1;
  logic       valid_out2;
  logic [7:0] data_out2;
  logic [1:0] stall_cnt2, bubble_cnt2;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 CLK = ~CLK;

  pipe_stage_reg #(.DW(8), .STAGES(3), .BUBBLE(Bub), .CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .stall(stall), .flush(flush),
    .clr_cnt(clr), .valid_in(vin), .data_in(din), .valid_out(valid_out),
    .data_out(data_out), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.DW(8), .STAGES(1), .BUBBLE(Bub), .CNT_W(2)) dut2 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit2), .dhit(1'b0), .stall(stall2), .flush(1'b0),
    .clr_cnt(clr2), .valid_in(vin2), .data_in(8'h3C), .valid_out(valid_out2),
    .data_out(data_out2), .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected outputs are queued at issue time; a flush squashes everything in flight.
  task automatic step(input logic v, input logic [7:0] d, input logic ih, input logic dh,
                      input logic st, input logic fl, input logic cl);
    vin = v; din = d; ihit = ih; dhit = dh; stall = st; flush = fl; clr = cl;
    if (fl) exp_q.delete();
    else if (nRST && v && (ih | dh) && !st) exp_q.push_back(d);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Monitor: a valid word presented after an advancing edge must be the next expected one.
  initial begin
    logic adv;
    logic [7:0] exp;
    forever begin
      @(posedge CLK);
      adv = nRST && !flush && (ihit | dhit) && !stall;
      #1;
      if (adv && valid_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: got %0h with nothing expected", data_out);
        end else begin
          exp = exp_q.pop_front();
          if (data_out !== exp) begin
            errors++;
            $display("FAIL scoreboard: got %0h expected %0h", data_out, exp);
          end
        end
      end
    end
  end

  initial begin
    // Reset with an active valid input and hit
    nRST = 1'b0;
    step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'(Bub));
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
    chk("rst2_valid", 32'(valid_out2), 32'd0);
    chk("rst2_data", 32'(data_out2), 32'(Bub));
    chk("rst2_cnts", {28'd0, stall_cnt2, bubble_cnt2}, 32'd0);
    nRST = 1'b1;

    // Three-stage latency
    step(1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lat_not_early", 32'(valid_out), 32'd0);
    step(1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lat_valid", 32'(valid_out), 32'd1);
    chk("lat_data1", 32'(data_out), 32'd1);
    step(1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lat_data2", 32'(data_out), 32'd2);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drain_data4", 32'(data_out), 32'd4);
    chk("bubble_invalid_adv", 32'(bubble_cnt), 32'd2);

    // Stall holds the pipe with 5 on the output
    step(1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("stall_hold_data", 32'(data_out), 32'd5);
    chk("stall_hold_valid", 32'(valid_out), 32'd1);
    chk("stall_cnt4", 32'(stall_cnt), 32'd4);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("after_stall_data", 32'(data_out), 32'd6);
    chk("bubble_cnt4", 32'(bubble_cnt), 32'd4);

    // Cache-miss freeze mid-stream
    step(1'b1, 8'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("freeze_data", 32'(data_out), 32'd8);
    chk("freeze_valid", 32'(valid_out), 32'd1);
    chk("freeze_cnts", {stall_cnt, bubble_cnt}, {16'd4, 16'd4});
    step(1'b1, 8'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'd12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("resume_dhit_data", 32'(data_out), 32'd10);

    // Flush beats stall and hit
    step(1'b1, 8'd13, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("flush_valid", 32'(valid_out), 32'd0);
    chk("flush_data", 32'(data_out), 32'(Bub));
    chk("flush_cnts", {stall_cnt, bubble_cnt}, {16'd4, 16'd5});
    step(1'b1, 8'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_bubble_mid", {23'd0, valid_out, data_out}, {23'd0, 1'b0, Bub});
    step(1'b1, 8'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_flush_data", 32'(data_out), 32'd14);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drain_cnts", {stall_cnt, bubble_cnt}, {16'd4, 16'd7});

    // Clear wins over a bubble increment
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_cnts", {stall_cnt, bubble_cnt}, 32'd0);

    // Saturation on the 2-bit-counter instance (main instance idles)
    ihit2 = 1'b1; stall2 = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_stall_cnt", 32'(stall_cnt2), 32'd3);
    clr2 = 1'b1;
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_clr_stall", 32'(stall_cnt2), 32'd0);
    clr2 = 1'b0;
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_after_clr", 32'(stall_cnt2), 32'd1);
    stall2 = 1'b0;
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s1_latency", {23'd0, valid_out2, data_out2}, {23'd0, 1'b1, 8'h3C});
    vin2 = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_bubble_cnt", 32'(bubble_cnt2), 32'd3);
    chk("invalid_keeps_data", {23'd0, valid_out2, data_out2}, {23'd0, 1'b0, 8'h3C});
    chk("main_idle_cnts", {stall_cnt, bubble_cnt}, 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
